evr_mapram_ctrl: RTL
====================

Name: evr_mapram_ctrl

Overview:
- Controller for the event mapping RAM, a two-bank, 2x256 x 16-bit dual-port RAM external to this block.
- Owns the RAM write port, which carries VME host writes with auto-increment pointer, and a full-bank clear sequencer.
- Drives the read port for per-cycle event-code lookup from the received data stream, with write-to-read bypass.
- Sits between the VME register set and the pulse generators, in the event clock domain.

Parameters:
- CODE_W, 8, event code width; the RAM address is {bank, code}, CODE_W+1 bits.
- DATA_W, 16, mapping word width.

Ports:
- clk_i  in  1  event clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- ram_enable_i  in  1  lookup enable; 0 forces the map output to zero.
- lookup_bank_i  in  1  bank used for event lookups.
- host_bank_i  in  1  bank targeted by host writes and clears.
- clear_req_i  in  1  level input; a rising edge starts a clear.
- wraddr_autoi_i  in  1  1 = use the internal pointer as write address.
- wraddr_reset_i  in  1  single-cycle pulse; sets the pointer to 0.
- wraddr_i  in  CODE_W  explicit write address.
- wrdata_i  in  DATA_W  host write data.
- wr_strobe_i  in  1  single-cycle host write request, already synchronised to clk_i.
- event_code_i  in  CODE_W  received event code, one per cycle.
- ram_raddr_o  out  CODE_W+1  read address.
- ram_rdata_i  in  DATA_W  read data, one cycle after the address.
- ram_we_o  out  1  write enable.
- ram_waddr_o  out  CODE_W+1  write address.
- ram_wdata_o  out  DATA_W  write data.
- map_out_o  out  DATA_W  mapped pulse-trigger word.
- map_valid_o  out  1  map_out_o holds a lookup of a non-zero code.
- clear_ready_o  out  1  1 = no clear in progress.
- wr_pending_o  out  1  a host write is buffered.
- wr_drop_o  out  1  sticky: a host write was lost.

Behaviour:
- Reset values: all outputs 0 except clear_ready_o = 1. Write pointer = 0. FSM = IDLE.
- Lookup pipeline, fixed 3-cycle latency:
  - Cycle N: event_code_i sampled.
  - Cycle N+1: ram_raddr_o = {lookup_bank_i, code}, registered.
  - Cycle N+2: ram_rdata_i valid.
  - Cycle N+3: map_out_o / map_valid_o registered.
- Code 0x00, or ram_enable_i = 0 at the N+2 stage: map_out_o = 0, map_valid_o = 0.
- Bypass: if ram_we_o = 1 and ram_waddr_o == ram_raddr_o in the same cycle, flag the stage. At N+3, map_out_o = that ram_wdata_o instead of ram_rdata_i (write-first semantics over a read-first RAM).
- FSM IDLE:
  - wr_strobe_i -> one-cycle write.
  - Address = {host_bank_i, autoi ? ptr : wraddr_i}.
  - If autoi, ptr <= ptr+1, mod 2^CODE_W, wrapping 255 -> 0.
  - wraddr_reset_i in the same cycle as the strobe: the write uses address 0, then ptr = 1.
  - wraddr_reset_i alone: ptr = 0.
- FSM IDLE -> CLEAR on a clear_req_i rising edge:
  - Latch host_bank_i.
  - clear_ready_o = 0 on the next cycle.
  - Write 0 to addresses 0..255 of the latched bank, one per cycle, 256 writes.
  - After the last write: clear_ready_o = 1 and ptr = 0.
- Further rising edges during CLEAR are ignored.
- CLEAR -> PEND_WR -> IDLE: while in CLEAR, a wr_strobe_i is captured together with its resolved address and data, and its ptr increment is applied at capture.
  - wr_pending_o = 1 while a write is buffered.
  - The buffered write is issued in the cycle after the final clear write, then wr_pending_o = 0.
  - A second strobe while pending is discarded and sets wr_drop_o.
  - wr_drop_o is cleared only by reset or by the start of the next clear.
- Clear and strobe starting in the same IDLE cycle: the strobe is buffered and written after the clear, so the written value survives.
- Bank changes mid-clear do not affect the latched bank. lookup_bank_i is sampled per lookup, at stage N.
- Asynchronous reset mid-clear aborts the clear. RAM contents are undefined; software must re-clear.

Decomposition:
- Shared package evr_map_pkg:
  - CODE_W, DATA_W.
  - NULL_CODE = 0.
  - FSM state enum {IDLE, CLEAR, PEND_WR}.
- One natural sub-module: evr_map_lookup_pipe, holding the 3-stage lookup, bypass compare and output gating.
- The FSM, pointer and write buffer stay in the top.

Test Plan:
- Reset release -> clear_ready_o = 1, map_out_o = 0, ram_we_o = 0; code 0x05 streamed -> map_valid_o stays 0 until written.
- Auto-increment: wraddr_reset then 3 strobes with data 0x0001, 0x0002, 0x0004, bank 0 -> writes at addresses 0x000, 0x001, 0x002; code 0x02 -> map_out_o = 0x0004 exactly 3 cycles later.
- Pointer wrap: ptr = 0xFF, one strobe -> write at 0x0FF, ptr = 0x00.
- Clear bank 1 with a strobe mid-clear (wraddr 0x10, data 0xBEEF):
  - clear_ready_o low for 256 cycles.
  - 0xBEEF written to 0x110 in the cycle after the clear.
  - A second strobe during the clear -> wr_drop_o = 1.
- Bypass: a lookup of code 0x33 in the same cycle as a write of 0x1234 to 0x033 -> map_out_o = 0x1234.
- ram_enable_i = 0 with a valid mapped code -> map_out_o = 0; asynchronous reset during CLEAR -> clear_ready_o = 1 immediately.

Source files
------------

// File: rtl/evr_map_pkg.sv
// ---------------------------------------------------------------------------
// evr_map_pkg
// Shared constants and types for the event mapping RAM controller.
//   CODE_W    : event code width; RAM address is {bank, code}.
//   DATA_W    : mapping word width.
//   ADDR_W    : RAM address width (bank bit + code).
//   NULL_CODE : the "no event" code, never produces a valid map word.
//   map_state_e : controller FSM states.
// ---------------------------------------------------------------------------
package evr_map_pkg;

    localparam int CODE_W = 8;
    localparam int DATA_W = 16;
    localparam int ADDR_W = CODE_W + 1;

    localparam logic [CODE_W-1:0] NULL_CODE = '0;
    localparam logic [CODE_W-1:0] CODE_ONE  = CODE_W'(1);
    localparam logic [CODE_W-1:0] CODE_MAX  = '1;

    // IDLE    : host writes go straight to the RAM write port.
    // CLEAR   : zero-fill of the latched bank, one word per cycle.
    // PEND_WR : clear finished; flush the buffered host write (if any).
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        PEND_WR = 2'd2
    } map_state_e;

endpackage

// File: rtl/evr_map_lookup_pipe.sv
// ---------------------------------------------------------------------------
// evr_map_lookup_pipe
// Three-stage event-code lookup into the mapping RAM read port.
//   clk_i, rst_n_i       : event clock, async active-low reset.
//   ram_enable_i         : gates the output at the final stage.
//   lookup_bank_i        : bank for the lookup, sampled with the code.
//   event_code_i         : received event code, one per cycle.
//   ram_we_i/waddr/wdata : current RAM write port, used for bypass.
//   ram_raddr_o          : registered read address {bank, code}.
//   ram_rdata_i          : RAM read data, one cycle after the address.
//   map_out_o            : mapped word, 3 cycles after the code.
//   map_valid_o          : map_out_o holds a lookup of a non-zero code.
// ---------------------------------------------------------------------------
module evr_map_lookup_pipe
    import evr_map_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ram_enable_i,
    input  logic              lookup_bank_i,
    input  logic [CODE_W-1:0] event_code_i,
    input  logic              ram_we_i,
    input  logic [ADDR_W-1:0] ram_waddr_i,
    input  logic [DATA_W-1:0] ram_wdata_i,
    output logic [ADDR_W-1:0] ram_raddr_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [DATA_W-1:0] map_out_o,
    output logic              map_valid_o
);

    logic              s1_nz;
    logic              s2_nz;
    logic              s2_byp;
    logic [DATA_W-1:0] s2_byp_data;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ram_raddr_o <= '0;
            s1_nz       <= 1'b0;
            s2_nz       <= 1'b0;
            s2_byp      <= 1'b0;
            s2_byp_data <= '0;
            map_out_o   <= '0;
            map_valid_o <= 1'b0;
        end else begin
            // Stage 1: present the read address.
            ram_raddr_o <= {lookup_bank_i, event_code_i};
            s1_nz       <= (event_code_i != NULL_CODE);

            // Stage 2: the RAM is read-first, so a write landing on the
            // address being read this cycle would return stale data.
            // Remember the write so the final stage can substitute it.
            s2_nz       <= s1_nz;
            s2_byp      <= ram_we_i && (ram_waddr_i == ram_raddr_o);
            s2_byp_data <= ram_wdata_i;

            // Stage 3: gate and register the result.
            if (ram_enable_i && s2_nz) begin
                map_out_o   <= s2_byp ? s2_byp_data : ram_rdata_i;
                map_valid_o <= 1'b1;
            end else begin
                map_out_o   <= '0;
                map_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/evr_mapram_ctrl.sv
// ---------------------------------------------------------------------------
// evr_mapram_ctrl
// Controller for the two-bank event mapping RAM (external dual-port RAM).
// Owns the write port (host writes with auto-increment pointer, full-bank
// clear sequencer) and drives the read port for per-cycle event lookups.
//   clk_i, rst_n_i   : event clock, async active-low reset.
//   ram_enable_i     : lookup enable; 0 forces map output to zero.
//   lookup_bank_i    : bank used for lookups.
//   host_bank_i      : bank targeted by host writes and clears.
//   clear_req_i      : level; rising edge starts a bank clear.
//   wraddr_autoi_i   : 1 = host write address comes from the pointer.
//   wraddr_reset_i   : pulse; pointer back to 0.
//   wraddr_i/wrdata_i/wr_strobe_i : host write request.
//   event_code_i     : received event code.
//   ram_*            : RAM read/write ports.
//   map_out_o/map_valid_o : lookup result.
//   clear_ready_o    : 1 = no clear in progress.
//   wr_pending_o     : a host write is buffered behind a clear.
//   wr_drop_o        : sticky, a host write was lost.
//   fsm_state_o      : debug view of the controller state.
//
// Host write handshake: wr_strobe_i is a single-cycle request with no
// ready/backpressure. In IDLE it is written on the next cycle. During a
// clear one request is buffered and written right after the clear; any
// further request while one is buffered is dropped and flagged.
// ---------------------------------------------------------------------------
module evr_mapram_ctrl
    import evr_map_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ram_enable_i,
    input  logic              lookup_bank_i,
    input  logic              host_bank_i,
    input  logic              clear_req_i,
    input  logic              wraddr_autoi_i,
    input  logic              wraddr_reset_i,
    input  logic [CODE_W-1:0] wraddr_i,
    input  logic [DATA_W-1:0] wrdata_i,
    input  logic              wr_strobe_i,
    input  logic [CODE_W-1:0] event_code_i,
    output logic [ADDR_W-1:0] ram_raddr_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic [DATA_W-1:0] map_out_o,
    output logic              map_valid_o,
    output logic              clear_ready_o,
    output logic              wr_pending_o,
    output logic              wr_drop_o,
    output logic [1:0]        fsm_state_o
);

    map_state_e        state;
    logic [CODE_W-1:0] ptr;
    logic [CODE_W-1:0] clr_cnt;
    logic              clr_bank;
    logic              clear_req_d;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;

    logic              clear_rise;
    logic [CODE_W-1:0] eff_ptr;
    logic [CODE_W-1:0] host_code;
    logic [ADDR_W-1:0] host_addr;
    logic [CODE_W-1:0] ptr_after_wr;

    assign clear_rise   = clear_req_i & ~clear_req_d;
    // A pointer reset in the same cycle as a strobe takes effect first,
    // so the write lands at 0 and the pointer ends at 1.
    assign eff_ptr      = wraddr_reset_i ? NULL_CODE : ptr;
    assign host_code    = wraddr_autoi_i ? eff_ptr : wraddr_i;
    assign host_addr    = {host_bank_i, host_code};
    assign ptr_after_wr = wraddr_autoi_i ? (eff_ptr + CODE_ONE) : eff_ptr;
    assign fsm_state_o  = state;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            ptr           <= '0;
            clr_cnt       <= '0;
            clr_bank      <= 1'b0;
            clear_req_d   <= 1'b0;
            pend_addr     <= '0;
            pend_data     <= '0;
            ram_we_o      <= 1'b0;
            ram_waddr_o   <= '0;
            ram_wdata_o   <= '0;
            clear_ready_o <= 1'b1;
            wr_pending_o  <= 1'b0;
            wr_drop_o     <= 1'b0;
        end else begin
            clear_req_d <= clear_req_i;
            ram_we_o    <= 1'b0;

            case (state)
                IDLE: begin
                    if (clear_rise) begin
                        // Issue clear word 0 immediately; the counter
                        // then walks 1..255 in CLEAR.
                        state         <= CLEAR;
                        clr_bank      <= host_bank_i;
                        clr_cnt       <= CODE_ONE;
                        clear_ready_o <= 1'b0;
                        wr_drop_o     <= 1'b0;
                        ram_we_o      <= 1'b1;
                        ram_waddr_o   <= {host_bank_i, NULL_CODE};
                        ram_wdata_o   <= '0;
                        if (wr_strobe_i) begin
                            wr_pending_o <= 1'b1;
                            pend_addr    <= host_addr;
                            pend_data    <= wrdata_i;
                            ptr          <= ptr_after_wr;
                        end else begin
                            ptr <= eff_ptr;
                        end
                    end else if (wr_strobe_i) begin
                        ram_we_o    <= 1'b1;
                        ram_waddr_o <= host_addr;
                        ram_wdata_o <= wrdata_i;
                        ptr         <= ptr_after_wr;
                    end else begin
                        ptr <= eff_ptr;
                    end
                end

                CLEAR: begin
                    ram_we_o    <= 1'b1;
                    ram_waddr_o <= {clr_bank, clr_cnt};
                    ram_wdata_o <= '0;
                    clr_cnt     <= clr_cnt + CODE_ONE;
                    if (clr_cnt == CODE_MAX) begin
                        state <= PEND_WR;
                    end
                    if (wr_strobe_i && !wr_pending_o) begin
                        wr_pending_o <= 1'b1;
                        pend_addr    <= host_addr;
                        pend_data    <= wrdata_i;
                        ptr          <= ptr_after_wr;
                    end else begin
                        if (wr_strobe_i) begin
                            wr_drop_o <= 1'b1;
                        end
                        ptr <= eff_ptr;
                    end
                end

                PEND_WR: begin
                    // The last clear word is on the port this cycle, so
                    // whatever is registered here follows it directly.
                    // The pointer reset of the clear wins over any
                    // increment requested in this cycle.
                    state         <= IDLE;
                    clear_ready_o <= 1'b1;
                    ptr           <= '0;
                    wr_pending_o  <= 1'b0;
                    if (wr_pending_o) begin
                        ram_we_o    <= 1'b1;
                        ram_waddr_o <= pend_addr;
                        ram_wdata_o <= pend_data;
                        if (wr_strobe_i) begin
                            wr_drop_o <= 1'b1;
                        end
                    end else if (wr_strobe_i) begin
                        ram_we_o    <= 1'b1;
                        ram_waddr_o <= host_addr;
                        ram_wdata_o <= wrdata_i;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    evr_map_lookup_pipe u_lookup (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .ram_enable_i  (ram_enable_i),
        .lookup_bank_i (lookup_bank_i),
        .event_code_i  (event_code_i),
        .ram_we_i      (ram_we_o),
        .ram_waddr_i   (ram_waddr_o),
        .ram_wdata_i   (ram_wdata_o),
        .ram_raddr_o   (ram_raddr_o),
        .ram_rdata_i   (ram_rdata_i),
        .map_out_o     (map_out_o),
        .map_valid_o   (map_valid_o)
    );

endmodule
